// File: rtl/tone_sequencer_if.sv
// Control/register and output bundle between the host side and the tone sequencer.
// Master drives the note table, config and start/stop; slave returns sine strobes and status.
interface tone_sequencer_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned DUR_W  = 12
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DIV_W-1:0]  wr_div;
    logic [DUR_W-1:0]  wr_dur;
    logic [ADDR_W-1:0] cfg_last;
    logic              loop_en;
    logic              start;
    logic              stop;
    logic              sin_clk;
    logic              phase_rst;
    logic              gate;
    logic              busy;
    logic [ADDR_W-1:0] note_idx;
    logic              done;

    modport master (
        output wr_en, wr_addr, wr_div, wr_dur, cfg_last, loop_en, start, stop,
        input  sin_clk, phase_rst, gate, busy, note_idx, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_div, wr_dur, cfg_last, loop_en, start, stop,
        output sin_clk, phase_rst, gate, busy, note_idx, done
    );
endinterface

// File: rtl/tone_sequencer.sv
// Plays a programmable table of {period, duration} notes, producing sine step strobes,
// a phase reset at each note start, and gate/busy/done status for the mixer.
module tone_sequencer #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned DIV_W    = 16,
    parameter int unsigned DUR_W    = 12,
    parameter int unsigned TICK_DIV = 48000
) (
    input  logic                 clk,
    input  logic                 reset,
    tone_sequencer_if.slave      bus
);
    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

    state_t            state;
    logic [DIV_W-1:0]  div_mem [DEPTH];
    logic [DUR_W-1:0]  dur_mem [DEPTH];
    logic [DIV_W-1:0]  div_r;
    logic [DIV_W-1:0]  div_cnt;
    logic [DUR_W-1:0]  dur_r;
    logic [DUR_W-1:0]  dur_cnt;
    logic [TICK_W-1:0] tick_cnt;
    logic [ADDR_W-1:0] note_idx;
    logic              done;

    logic [DUR_W-1:0]  load_dur;
    logic              div_wrap;
    logic              tick_wrap;
    logic              note_end;
    logic              is_last;

    // Note table: unreset storage, written any cycle; a same-cycle LOAD sees the old entry.
    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            div_mem[bus.wr_addr] <= bus.wr_div;
            dur_mem[bus.wr_addr] <= bus.wr_dur;
        end
    end

    assign load_dur  = dur_mem[note_idx];
    assign div_wrap  = (div_cnt == div_r - DIV_W'(1));
    assign tick_wrap = (tick_cnt == TICK_LAST);
    assign is_last   = (note_idx == bus.cfg_last);
    assign note_end  = ((state == PLAY) && tick_wrap && (dur_cnt == dur_r - DUR_W'(1)))
                    || ((state == LOAD) && (load_dur == '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            note_idx <= '0;
            div_r    <= '0;
            dur_r    <= '0;
            div_cnt  <= '0;
            tick_cnt <= '0;
            dur_cnt  <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        state    <= LOAD;
                        note_idx <= '0;
                    end
                end
                LOAD: begin
                    div_r    <= div_mem[note_idx];
                    dur_r    <= load_dur;
                    div_cnt  <= '0;
                    tick_cnt <= '0;
                    dur_cnt  <= '0;
                end
                PLAY: begin
                    div_cnt  <= ((div_r == '0) || div_wrap) ? '0 : div_cnt + DIV_W'(1);
                    tick_cnt <= tick_wrap ? '0 : tick_cnt + TICK_W'(1);
                    if (tick_wrap) dur_cnt <= dur_cnt + DUR_W'(1);
                end
                default: state <= IDLE;
            endcase

            // Sequencing: stop beats end-of-note; a zero-duration entry ends in its LOAD cycle.
            if (state != IDLE) begin
                if (bus.stop) begin
                    state <= IDLE;
                end else if (note_end) begin
                    if (!is_last) begin
                        note_idx <= note_idx + ADDR_W'(1);
                        state    <= LOAD;
                    end else if (bus.loop_en) begin
                        note_idx <= '0;
                        state    <= LOAD;
                    end else begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end else if (state == LOAD) begin
                    state <= PLAY;
                end
            end
        end
    end

    assign bus.sin_clk   = (state == PLAY) && (div_r != '0) && div_wrap && !bus.stop;
    assign bus.gate      = (state == PLAY) && (div_r != '0) && !bus.stop;
    assign bus.phase_rst = (state == LOAD) && !bus.stop;
    assign bus.busy      = (state != IDLE);
    assign bus.note_idx  = note_idx;
    assign bus.done      = done;
endmodule

// File: tb/tb_tone_sequencer.sv
// Scoreboard bench: each scenario queues the expected per-cycle output vector
// {sin_clk, phase_rst, gate, busy, done, note_idx}; a negedge monitor pops and compares.
module tb_tone_sequencer;
    localparam int unsigned TICK = 4;

    logic clk;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_fail;
    logic [8:0] exp_q[$];
    logic [8:0] exp_v;
    logic [8:0] got_v;

    tone_sequencer_if #(.ADDR_W(4), .DIV_W(16), .DUR_W(12)) bus ();

    tone_sequencer #(
        .DEPTH(16), .ADDR_W(4), .DIV_W(16), .DUR_W(12), .TICK_DIV(TICK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Compare one queued vector per cycle while expectations are pending.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            got_v = {bus.sin_clk, bus.phase_rst, bus.gate, bus.busy, bus.done, bus.note_idx};
            check($sformatf("cyc%0d", cyc), 32'(got_v), 32'(exp_v));
        end
    end

    task automatic push_v(input bit s, input bit p, input bit g, input bit b, input bit d,
                          input int idx);
        exp_q.push_back({s, p, g, b, d, 4'(idx)});
    endtask

    task automatic push_idle(input int idx);
        push_v(0, 0, 0, 0, 0, idx);
    endtask

    task automatic push_done(input int idx);
        push_v(0, 0, 0, 0, 1, idx);
    endtask

    // One LOAD cycle, then dur*TICK PLAY cycles striking every div-th cycle.
    task automatic push_note(input int div, input int dur, input int idx);
        push_v(0, 1, 0, 1, 0, idx);
        for (int k = 0; k < dur * TICK; k++)
            push_v((div != 0) && (((k + 1) % div) == 0), 0, div != 0, 1, 0, idx);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input int addr, input int div, input int dur);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'(addr);
        bus.wr_div  = 16'(div);
        bus.wr_dur  = 12'(dur);
        step(1);
        bus.wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check(tag, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        cyc = 0; n_checks = 0; n_fail = 0;
        reset = 1'b1;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_div = '0; bus.wr_dur = '0;
        bus.cfg_last = '0; bus.loop_en = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
        step(3);
        reset = 1'b0;

        // Reset state
        push_idle(0); push_idle(0);
        drain("reset");

        // Single note {3,2}
        wr(0, 3, 2);
        bus.cfg_last = 4'd0;
        push_idle(0); push_note(3, 2, 0); push_done(0); push_idle(0);
        pulse_start();
        drain("single");

        // Rest note and zero-duration entry
        wr(0, 2, 1); wr(1, 0, 1); wr(2, 1, 0);
        bus.cfg_last = 4'd2;
        push_idle(0); push_note(2, 1, 0); push_note(0, 1, 1); push_note(1, 0, 2);
        push_done(2); push_idle(2);
        pulse_start();
        drain("rest_skip");

        // Looping, then loop_en cleared during the second pass of note 1
        wr(0, 1, 1); wr(1, 2, 1);
        bus.cfg_last = 4'd1;
        bus.loop_en  = 1'b1;
        push_idle(2); push_note(1, 1, 0); push_note(2, 1, 1);
        push_note(1, 1, 0); push_note(2, 1, 1); push_done(1); push_idle(1);
        pulse_start();
        step(16);
        bus.loop_en = 1'b0;
        drain("loop");

        // Stop on a cycle where sin_clk would have fired
        wr(0, 1, 1); wr(1, 3, 2);
        push_idle(1); push_note(1, 1, 0);
        push_v(0, 1, 0, 1, 0, 1);
        push_v(0, 0, 1, 1, 0, 1);
        push_v(0, 0, 1, 1, 0, 1);
        push_v(0, 0, 0, 1, 0, 1);
        push_idle(1); push_idle(1);
        pulse_start();
        step(8);
        bus.stop = 1'b1;
        step(1);
        bus.stop = 1'b0;
        drain("stop");

        // Restart after stop begins at entry 0
        bus.cfg_last = 4'd0;
        push_idle(1); push_note(1, 1, 0); push_done(0);
        pulse_start();
        drain("restart");

        // Table write during playback is used at the next LOAD
        wr(0, 2, 2); wr(1, 1, 1);
        bus.cfg_last = 4'd1;
        push_idle(0); push_note(2, 2, 0); push_note(3, 1, 1); push_done(1);
        pulse_start();
        step(2);
        wr(1, 3, 1);
        drain("wr_live");

        // Write coinciding with entry 1's LOAD: old value plays, new one next time
        push_idle(1); push_note(2, 2, 0); push_note(3, 1, 1); push_done(1);
        pulse_start();
        step(9);
        wr(1, 2, 1);
        drain("wr_same");
        push_idle(1); push_note(2, 2, 0); push_note(2, 1, 1); push_done(1);
        pulse_start();
        drain("wr_after");

        // Reset during entry 1 PLAY
        wr(0, 1, 1); wr(1, 3, 2);
        push_idle(1); push_note(1, 1, 0);
        push_v(0, 1, 0, 1, 0, 1);
        push_v(0, 0, 1, 1, 0, 1);
        push_v(0, 0, 1, 1, 0, 1);
        push_idle(0); push_idle(0);
        pulse_start();
        step(7);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        drain("reset_mid");

        // start+stop together from IDLE, then stop alone: no effect
        push_idle(0); push_idle(0); push_idle(0); push_idle(0);
        bus.start = 1'b1; bus.stop = 1'b1;
        step(1);
        bus.start = 1'b0;
        step(1);
        bus.stop = 1'b0;
        drain("start_stop");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks %0d failures %0d", n_checks, n_fail);
        $fatal(1);
    end
endmodule
